// File: rtl/stage3.sv
// stage3: RV32I execute stage; ALU, branch resolve and EX/MEM pipeline registers.
// Define STAGE3_MUL_EN to build the iterative shift-add multiplier and its stall.
module stage3 (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        idexValid,
  input  logic [31:0] idexPc,
  input  logic [31:0] idexData1,
  input  logic [31:0] idexData2,
  input  logic [4:0]  idexRd,
  input  logic [6:0]  idexFunc7,
  input  logic [2:0]  idexFunc3,
  input  logic [63:0] idexExpandInst,
  input  logic [2:0]  idexExCtrl,
  input  logic [2:0]  idexMemCtrl,
  input  logic [1:0]  idexWbCtrl,
  output logic        exStall,
  output logic        exmemValid,
  output logic [31:0] exmemAluResult,
  output logic [31:0] exmemData2,
  output logic [4:0]  exmemRd,
  output logic [31:0] exmemBranchTarget,
  output logic        exmemBranchTaken,
  output logic [2:0]  exmemMemCtrl,
  output logic [1:0]  exmemWbCtrl
);
  // state | meaning
  // IDLE  | single-cycle execute; a MUL in ID/EX loads the multiplier
  // BUSY  | one shift-add iteration per edge, upstream held until the last

  logic [1:0]  alu_op;
  logic [31:0] imm, op_a, op_b, alu_res, sra_res, target;
  logic        taken_dec;
  logic        stall, mul_bubble, mul_done;
  logic [31:0] mul_res;
  logic        nxt_valid, nxt_taken;
  logic [31:0] nxt_res;
  logic [2:0]  nxt_mem;
  logic [1:0]  nxt_wb;
  logic        unused_bits;

  assign alu_op  = idexExCtrl[2:1];
  assign imm     = idexExpandInst[31:0];
  assign op_a    = idexData1;
  assign op_b    = idexExCtrl[0] ? imm : idexData2;
  assign target  = idexPc + imm;
  assign sra_res = $signed(op_a) >>> op_b[4:0];
  assign unused_bits = ^{idexExpandInst[63:32], idexFunc7};

  always_comb begin
    alu_res   = op_a + op_b;
    taken_dec = 1'b0;
    case (alu_op)
      2'b01: begin
        alu_res = op_a - op_b;
        case (idexFunc3)
          3'b000:  taken_dec = (op_a == op_b);
          3'b001:  taken_dec = (op_a != op_b);
          3'b100:  taken_dec = ($signed(op_a) < $signed(op_b));
          3'b101:  taken_dec = ($signed(op_a) >= $signed(op_b));
          3'b110:  taken_dec = (op_a < op_b);
          3'b111:  taken_dec = (op_a >= op_b);
          default: taken_dec = 1'b0;
        endcase
      end
      2'b10, 2'b11: begin
        case (idexFunc3)
          // immediate forms never subtract; bit 5 of funct7 is immediate data there
          3'b000:  alu_res = (alu_op == 2'b10 && idexFunc7[5]) ? op_a - op_b : op_a + op_b;
          3'b001:  alu_res = op_a << op_b[4:0];
          3'b010:  alu_res = {31'b0, $signed(op_a) < $signed(op_b)};
          3'b011:  alu_res = {31'b0, op_a < op_b};
          3'b100:  alu_res = op_a ^ op_b;
          3'b101:  alu_res = idexFunc7[5] ? sra_res : op_a >> op_b[4:0];
          3'b110:  alu_res = op_a | op_b;
          default: alu_res = op_a & op_b;
        endcase
      end
      default: ;
    endcase
  end

`ifdef STAGE3_MUL_EN
  typedef enum logic {IDLE, BUSY} state_t;
  state_t      state, state_nxt;
  logic [31:0] mcand, mplier, acc, acc_step;
  logic [4:0]  count;
  logic        is_mul, last_iter;

  assign is_mul    = idexValid & (alu_op == 2'b10) & (idexFunc7 == 7'b0000001) & (idexFunc3 == 3'b000);
  assign last_iter = (count == 5'd31);
  assign acc_step  = mplier[0] ? acc + mcand : acc;
  assign mul_res   = acc_step;

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      count  <= '0;
    end else if (state == IDLE) begin
      if (is_mul) begin
        mcand  <= op_a;
        mplier <= op_b;
        acc    <= '0;
        count  <= '0;
      end
    end else begin
      acc    <= acc_step;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      count  <= count + 5'd1;
    end
  end

  always_comb begin
    state_nxt  = state;
    stall      = 1'b0;
    mul_bubble = 1'b0;
    mul_done   = 1'b0;
    case (state)
      IDLE: begin
        if (is_mul) begin
          state_nxt  = BUSY;
          stall      = 1'b1;
          mul_bubble = 1'b1;
        end
      end
      BUSY: begin
        if (last_iter) begin
          state_nxt = IDLE;
          mul_done  = 1'b1;
        end else begin
          stall      = 1'b1;
          mul_bubble = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end
`else
  assign stall      = 1'b0;
  assign mul_bubble = 1'b0;
  assign mul_done   = 1'b0;
  assign mul_res    = '0;
`endif

  assign exStall = stall & rst_n;

  // rd and control of a finishing MUL come straight from ID/EX, held by the stall
  always_comb begin
    nxt_valid = idexValid;
    nxt_res   = alu_res;
    nxt_taken = idexValid & idexMemCtrl[2] & taken_dec;
    nxt_mem   = idexValid ? idexMemCtrl : 3'b000;
    nxt_wb    = idexValid ? idexWbCtrl : 2'b00;
    if (mul_bubble) begin
      nxt_valid = 1'b0;
      nxt_taken = 1'b0;
      nxt_mem   = 3'b000;
      nxt_wb    = 2'b00;
    end else if (mul_done) begin
      nxt_valid = 1'b1;
      nxt_res   = mul_res;
      nxt_taken = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      exmemValid        <= 1'b0;
      exmemAluResult    <= '0;
      exmemData2        <= '0;
      exmemRd           <= '0;
      exmemBranchTarget <= '0;
      exmemBranchTaken  <= 1'b0;
      exmemMemCtrl      <= '0;
      exmemWbCtrl       <= '0;
    end else begin
      exmemValid        <= nxt_valid;
      exmemAluResult    <= nxt_res;
      exmemData2        <= idexData2;
      exmemRd           <= idexRd;
      exmemBranchTarget <= target;
      exmemBranchTaken  <= nxt_taken;
      exmemMemCtrl      <= nxt_mem;
      exmemWbCtrl       <= nxt_wb;
    end
  end
endmodule
